// File: rtl/bbcpu_pkg.sv
// bbcpu_pkg: shared constants for the 8-bit bus CPU control path.
//   - opcode constants OP_NOP..OP_HLT
//   - T-state constants T0..T4
//   - control-word bit indices shared by the decoder and any microcode dump
//   - has_execute(): whether an opcode has any execute step after fetch
package bbcpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Datapath strobes occupy the low bits; the top four bits are
    // sequencer-internal (IR load, halt request, flag capture, last step).
    localparam int CW_IR_OUT     = 0;
    localparam int CW_MAR_WRITE  = 1;
    localparam int CW_PC_OUT     = 2;
    localparam int CW_PC_ENABLE  = 3;
    localparam int CW_PC_LOAD    = 4;
    localparam int CW_RAM_OUT    = 5;
    localparam int CW_RAM_WRITE  = 6;
    localparam int CW_REGA_WE    = 7;
    localparam int CW_REGB_WE    = 8;
    localparam int CW_REGA_EN    = 9;
    localparam int CW_REGB_EN    = 10;
    localparam int CW_ALU_EN     = 11;
    localparam int CW_SUB_EN     = 12;
    localparam int CW_OUT_WRITE  = 13;
    localparam int CW_IR_WRITE   = 14;
    localparam int CW_HALT       = 15;
    localparam int CW_FLAGS      = 16;
    localparam int CW_LAST       = 17;
    localparam int CW_W          = 18;

    typedef logic [CW_W-1:0] ctrl_word_t;

    function automatic logic has_execute(input logic [3:0] op);
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
            OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: has_execute = 1'b1;
            default:                              has_execute = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: purely combinational microcode decode.
//   opcode_i      IR opcode field
//   step_i        current T-state
//   carry_flag_i  registered carry flag (JC condition)
//   zero_flag_i   registered zero flag (JZ condition)
//   halted_i      CPU halted; forces an all-zero control word
//   ctrl_o        control word, bit layout from bbcpu_pkg
// The fetch-side end of NOP/undefined instructions is decided by the top
// level from the incoming bus, because the IR still holds the previous
// instruction during T1.
module control_decode
    import bbcpu_pkg::*;
(
    input  logic [3:0]  opcode_i,
    input  logic [2:0]  step_i,
    input  logic        carry_flag_i,
    input  logic        zero_flag_i,
    input  logic        halted_i,
    output ctrl_word_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        if (!halted_i) begin
            case (step_i)
                T0: begin
                    ctrl_o[CW_PC_OUT]    = 1'b1;
                    ctrl_o[CW_MAR_WRITE] = 1'b1;
                end
                T1: begin
                    ctrl_o[CW_RAM_OUT]   = 1'b1;
                    ctrl_o[CW_IR_WRITE]  = 1'b1;
                    ctrl_o[CW_PC_ENABLE] = 1'b1;
                end
                T2: begin
                    case (opcode_i)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl_o[CW_IR_OUT]    = 1'b1;
                            ctrl_o[CW_MAR_WRITE] = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl_o[CW_IR_OUT]  = 1'b1;
                            ctrl_o[CW_REGA_WE] = 1'b1;
                            ctrl_o[CW_LAST]    = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl_o[CW_IR_OUT]  = 1'b1;
                            ctrl_o[CW_PC_LOAD] = 1'b1;
                            ctrl_o[CW_LAST]    = 1'b1;
                        end
                        OP_JC: begin
                            ctrl_o[CW_IR_OUT]  = carry_flag_i;
                            ctrl_o[CW_PC_LOAD] = carry_flag_i;
                            ctrl_o[CW_LAST]    = 1'b1;
                        end
                        OP_JZ: begin
                            ctrl_o[CW_IR_OUT]  = zero_flag_i;
                            ctrl_o[CW_PC_LOAD] = zero_flag_i;
                            ctrl_o[CW_LAST]    = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl_o[CW_REGA_EN]   = 1'b1;
                            ctrl_o[CW_OUT_WRITE] = 1'b1;
                            ctrl_o[CW_LAST]      = 1'b1;
                        end
                        OP_HLT: begin
                            ctrl_o[CW_HALT] = 1'b1;
                            ctrl_o[CW_LAST] = 1'b1;
                        end
                        default: ctrl_o[CW_LAST] = 1'b1;
                    endcase
                end
                T3: begin
                    case (opcode_i)
                        OP_LDA: begin
                            ctrl_o[CW_RAM_OUT] = 1'b1;
                            ctrl_o[CW_REGA_WE] = 1'b1;
                            ctrl_o[CW_LAST]    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl_o[CW_RAM_OUT] = 1'b1;
                            ctrl_o[CW_REGB_WE] = 1'b1;
                        end
                        OP_STA: begin
                            ctrl_o[CW_REGA_EN]   = 1'b1;
                            ctrl_o[CW_RAM_WRITE] = 1'b1;
                            ctrl_o[CW_LAST]      = 1'b1;
                        end
                        default: ctrl_o[CW_LAST] = 1'b1;
                    endcase
                end
                default: begin
                    // T4 only exists for ADD/SUB; any other combination
                    // simply returns to fetch.
                    ctrl_o[CW_LAST] = 1'b1;
                    if (step_i == T4 && (opcode_i == OP_ADD || opcode_i == OP_SUB)) begin
                        ctrl_o[CW_ALU_EN]  = 1'b1;
                        ctrl_o[CW_REGA_WE] = 1'b1;
                        ctrl_o[CW_FLAGS]   = 1'b1;
                        ctrl_o[CW_SUB_EN]  = (opcode_i == OP_SUB);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit for the 8-bit bus CPU.
// Holds the instruction register, T-state counter, carry/zero flags and the
// sticky halt bit; strobes are a Moore decode of that state.
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   bus_in            shared bus: IR source at T1, zero-test at ADD/SUB T4
//   carry             ALU carry-out, captured at ADD/SUB T4
//   operand           IR operand field
//   ir_out .. out_write  datapath and ALU-block strobes
//   halted            CPU stopped
//   carry_flag, zero_flag  registered flags
module control_sequencer
    import bbcpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             carry,
    output logic [WIDTH-5:0] operand,
    output logic             ir_out,
    output logic             mar_write,
    output logic             pc_out,
    output logic             pc_enable,
    output logic             pc_load,
    output logic             ram_out,
    output logic             ram_write,
    output logic             rega_write_enable,
    output logic             regb_write_enable,
    output logic             rega_enable,
    output logic             regb_enable,
    output logic             alu_enable,
    output logic             sub_enable,
    output logic             out_write,
    output logic             halted,
    output logic             carry_flag,
    output logic             zero_flag
);

    logic [2:0]       step_q, step_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic             carry_flag_q, carry_flag_d;
    logic             zero_flag_q, zero_flag_d;
    logic             halted_q, halted_d;
    ctrl_word_t       ctrl;

    control_decode u_decode (
        .opcode_i     (ir_q[WIDTH-1 -: 4]),
        .step_i       (step_q),
        .carry_flag_i (carry_flag_q),
        .zero_flag_i  (zero_flag_q),
        .halted_i     (halted_q),
        .ctrl_o       (ctrl)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q       <= T0;
            ir_q         <= '0;
            carry_flag_q <= 1'b0;
            zero_flag_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            step_q       <= step_d;
            ir_q         <= ir_d;
            carry_flag_q <= carry_flag_d;
            zero_flag_q  <= zero_flag_d;
            halted_q     <= halted_d;
        end
    end

    // Next-state logic. Once halted, everything holds (step is already T0).
    always_comb begin
        step_d       = step_q;
        ir_d         = ir_q;
        carry_flag_d = carry_flag_q;
        zero_flag_d  = zero_flag_q;
        halted_d     = halted_q;
        if (!halted_q) begin
            if (ctrl[CW_IR_WRITE]) begin
                ir_d = bus_in;
            end
            if (ctrl[CW_FLAGS]) begin
                carry_flag_d = carry;
                zero_flag_d  = (bus_in == '0);
            end
            if (ctrl[CW_HALT]) begin
                halted_d = 1'b1;
            end
            // At T1 the new opcode is only on the bus, so the NOP/undefined
            // early return is decided from bus_in rather than the IR.
            if (step_q == T1) begin
                step_d = has_execute(bus_in[WIDTH-1 -: 4]) ? T2 : T0;
            end else if (ctrl[CW_LAST]) begin
                step_d = T0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    // Output decode.
    always_comb begin
        operand           = ir_q[WIDTH-5:0];
        ir_out            = ctrl[CW_IR_OUT];
        mar_write         = ctrl[CW_MAR_WRITE];
        pc_out            = ctrl[CW_PC_OUT];
        pc_enable         = ctrl[CW_PC_ENABLE];
        pc_load           = ctrl[CW_PC_LOAD];
        ram_out           = ctrl[CW_RAM_OUT];
        ram_write         = ctrl[CW_RAM_WRITE];
        rega_write_enable = ctrl[CW_REGA_WE];
        regb_write_enable = ctrl[CW_REGB_WE];
        rega_enable       = ctrl[CW_REGA_EN];
        regb_enable       = ctrl[CW_REGB_EN];
        alu_enable        = ctrl[CW_ALU_EN];
        sub_enable        = ctrl[CW_SUB_EN];
        out_write         = ctrl[CW_OUT_WRITE];
        halted            = halted_q;
        carry_flag        = carry_flag_q;
        zero_flag         = zero_flag_q;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: each instruction pushes its
// expected per-cycle outputs into a scoreboard queue, then the cycles are
// driven and each sampled cycle is popped and compared.
module tb_control_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       carry;
    logic [3:0] operand;
    logic ir_out, mar_write, pc_out, pc_enable, pc_load, ram_out, ram_write;
    logic rega_write_enable, regb_write_enable, rega_enable, regb_enable;
    logic alu_enable, sub_enable, out_write, halted, carry_flag, zero_flag;

    control_sequencer #(.WIDTH(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus_in            (bus_in),
        .carry             (carry),
        .operand           (operand),
        .ir_out            (ir_out),
        .mar_write         (mar_write),
        .pc_out            (pc_out),
        .pc_enable         (pc_enable),
        .pc_load           (pc_load),
        .ram_out           (ram_out),
        .ram_write         (ram_write),
        .rega_write_enable (rega_write_enable),
        .regb_write_enable (regb_write_enable),
        .rega_enable       (rega_enable),
        .regb_enable       (regb_enable),
        .alu_enable        (alu_enable),
        .sub_enable        (sub_enable),
        .out_write         (out_write),
        .halted            (halted),
        .carry_flag        (carry_flag),
        .zero_flag         (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe bit masks in the bench's own packing order.
    localparam logic [13:0] S_IRO  = 14'h2000;
    localparam logic [13:0] S_MAR  = 14'h1000;
    localparam logic [13:0] S_PCO  = 14'h0800;
    localparam logic [13:0] S_PCE  = 14'h0400;
    localparam logic [13:0] S_PCL  = 14'h0200;
    localparam logic [13:0] S_RAMO = 14'h0100;
    localparam logic [13:0] S_RAMW = 14'h0080;
    localparam logic [13:0] S_AWE  = 14'h0040;
    localparam logic [13:0] S_BWE  = 14'h0020;
    localparam logic [13:0] S_AEN  = 14'h0010;
    localparam logic [13:0] S_BEN  = 14'h0008;
    localparam logic [13:0] S_ALU  = 14'h0004;
    localparam logic [13:0] S_SUB  = 14'h0002;
    localparam logic [13:0] S_OUTW = 14'h0001;

    typedef struct packed {
        logic [13:0] strb;
        logic [3:0]  op;
        logic        h;
        logic        cf;
        logic        zf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state.
    logic [3:0] m_op;
    logic       m_cf, m_zf, m_halt;

    function automatic logic [13:0] dut_strobes();
        return {ir_out, mar_write, pc_out, pc_enable, pc_load, ram_out, ram_write,
                rega_write_enable, regb_write_enable, rega_enable, regb_enable,
                alu_enable, sub_enable, out_write};
    endfunction

    function automatic int instr_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4:                         return 4;
            4'h2, 4'h3:                         return 5;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3;
            default:                            return 2;
        endcase
    endfunction

    function automatic logic [13:0] exp_strobe(input logic [3:0] op, input int k,
                                               input logic cf, input logic zf);
        logic [13:0] s;
        s = '0;
        case (k)
            0: s = S_PCO | S_MAR;
            1: s = S_RAMO | S_PCE;
            2: case (op)
                   4'h1, 4'h2, 4'h3, 4'h4: s = S_IRO | S_MAR;
                   4'h5: s = S_IRO | S_AWE;
                   4'h6: s = S_IRO | S_PCL;
                   4'h7: s = cf ? (S_IRO | S_PCL) : 14'h0;
                   4'h8: s = zf ? (S_IRO | S_PCL) : 14'h0;
                   4'hE: s = S_AEN | S_OUTW;
                   default: s = '0;
               endcase
            3: case (op)
                   4'h1: s = S_RAMO | S_AWE;
                   4'h2, 4'h3: s = S_RAMO | S_BWE;
                   4'h4: s = S_AEN | S_RAMW;
                   default: s = '0;
               endcase
            4: s = S_ALU | S_AWE | ((op == 4'h3) ? S_SUB : 14'h0);
            default: s = '0;
        endcase
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Pop one expected cycle and compare it with the current DUT outputs.
    task automatic compare_cycle(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard-empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " strobes"}, 32'(dut_strobes()), 32'(e.strb));
        check({tag, " operand"}, 32'(operand), 32'(e.op));
        check({tag, " halted"}, 32'(halted), 32'(e.h));
        check({tag, " flags"}, 32'({carry_flag, zero_flag}), 32'({e.cf, e.zf}));
    endtask

    // Entered just after a falling edge with the DUT at T0. ncyc=0 runs the
    // whole instruction; otherwise only the first ncyc cycles are checked and
    // the caller is expected to reset.
    task automatic run_instr(input logic [7:0] instr, input logic [7:0] alu_bus,
                             input logic alu_carry, input int ncyc);
        int   len;
        exp_t e;
        len = instr_len(instr[7:4]);
        if (ncyc != 0) len = ncyc;
        for (int k = 0; k < len; k++) begin
            e.strb = exp_strobe(instr[7:4], k, m_cf, m_zf);
            e.op   = (k >= 2) ? instr[3:0] : m_op;
            e.h    = 1'b0;
            e.cf   = m_cf;
            e.zf   = m_zf;
            exp_q.push_back(e);
        end
        for (int k = 0; k < len; k++) begin
            compare_cycle($sformatf("%02h T%0d", instr, k));
            $display("[TB] instr %02h T%0d strobes=%04h operand=%0h", instr, k,
                     dut_strobes(), operand);
            if (ncyc != 0 && k == len - 1) return;
            bus_in = (k == 1) ? instr : ((k == 4) ? alu_bus : 8'($urandom));
            carry  = (k == 4) ? alu_carry : 1'($urandom);
            @(negedge clk);
        end
        if (instr[7:4] == 4'h2 || instr[7:4] == 4'h3) begin
            m_cf = alu_carry;
            m_zf = (alu_bus == 8'h00);
        end
        m_op = instr[3:0];
        if (instr[7:4] == 4'hF) m_halt = 1'b1;
    endtask

    // Asynchronous reset in the low phase; outputs must reach the T0 decode
    // before any clock edge. Returns just after a falling edge, reset released.
    task automatic reset_pulse(input string tag);
        exp_t e;
        #2 rst_n = 1'b0;
        #1;
        m_op = 4'h0; m_cf = 1'b0; m_zf = 1'b0; m_halt = 1'b0;
        e.strb = S_PCO | S_MAR; e.op = 4'h0; e.h = 1'b0; e.cf = 1'b0; e.zf = 1'b0;
        exp_q.push_back(e);
        compare_cycle(tag);
        $display("[TB] reset %s strobes=%04h", tag, dut_strobes());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n  = 1'b1;
        bus_in = 8'h00;
        carry  = 1'b0;
        m_op = 4'h0; m_cf = 1'b0; m_zf = 1'b0; m_halt = 1'b0;

        reset_pulse("init");
        run_instr(8'h57, 8'h00, 1'b0, 0);   // LDI 7
        run_instr(8'h1A, 8'h00, 1'b0, 0);   // LDA
        run_instr(8'h73, 8'h00, 1'b0, 0);   // JC, not taken
        run_instr(8'h85, 8'h00, 1'b0, 0);   // JZ, not taken
        run_instr(8'h2B, 8'h00, 1'b1, 0);   // ADD: carry=1, zero=1
        run_instr(8'h73, 8'h00, 1'b0, 0);   // JC, taken
        run_instr(8'h84, 8'h00, 1'b0, 0);   // JZ, taken
        run_instr(8'h3C, 8'h05, 1'b0, 0);   // SUB: flags cleared
        run_instr(8'h89, 8'h00, 1'b0, 0);   // JZ, not taken
        run_instr(8'h4D, 8'h00, 1'b0, 0);   // STA
        run_instr(8'hE0, 8'h00, 1'b0, 0);   // OUT
        run_instr(8'h00, 8'h00, 1'b0, 0);   // NOP
        run_instr(8'h9A, 8'h00, 1'b0, 0);   // undefined
        run_instr(8'hB1, 8'h00, 1'b0, 0);   // undefined
        run_instr(8'h62, 8'h00, 1'b0, 0);   // JMP
        run_instr(8'h2E, 8'h80, 1'b1, 0);   // ADD: carry=1, zero=0
        run_instr(8'h76, 8'h00, 1'b0, 0);   // JC, taken

        // Abort LDA in T3 with reset.
        run_instr(8'h1F, 8'h00, 1'b0, 4);
        reset_pulse("lda-abort");
        run_instr(8'h53, 8'h00, 1'b0, 0);

        // Halt and stay halted.
        run_instr(8'hF0, 8'h00, 1'b0, 0);
        for (int i = 0; i < 22; i++) begin
            e.strb = '0; e.op = m_op; e.h = m_halt; e.cf = m_cf; e.zf = m_zf;
            exp_q.push_back(e);
            compare_cycle($sformatf("halt c%0d", i));
            $display("[TB] halted cycle %0d strobes=%04h halted=%0b", i, dut_strobes(), halted);
            bus_in = 8'($urandom);
            carry  = 1'($urandom);
            @(negedge clk);
        end
        reset_pulse("post-halt");
        run_instr(8'h5C, 8'h00, 1'b0, 0);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
